comp_result_monitor: RTL and testbench
======================================

Name: comp_result_monitor

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its less/greater/eq flags one sample per qualified cycle.
- Accumulates per-outcome statistics and tracks the current run of consecutive equal results.
- Runs a lock FSM that declares "operands matched" after a sustained run of eq results, with hysteresis on release.
- Sticky-flags any flag pattern that is not exactly one-hot, catching comparator or wiring faults.

Parameters:
- CNT_W, 8, width of every counter and of run_len.
- LOCK_LEN, 4, consecutive eq samples needed to enter lock (legal 1..2^CNT_W-1).
- UNLOCK_LEN, 2, consecutive non-eq samples needed to leave lock (legal >=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- in_valid  in  1  comparator flags valid this cycle; sample accepted.
- less  in  1  comparator a_in < b_in.
- greater  in  1  comparator a_in > b_in.
- eq  in  1  comparator a_in == b_in.
- clr  in  1  synchronous soft clear of statistics, FSM and error flag.
- less_cnt  out  CNT_W  accepted valid "less" samples, saturating.
- greater_cnt  out  CNT_W  accepted valid "greater" samples, saturating.
- eq_cnt  out  CNT_W  accepted valid "eq" samples, saturating.
- run_len  out  CNT_W  current consecutive valid-eq run length, saturating.
- lock  out  1  operands matched; equals (state != SEARCH).
- state  out  2  FSM state: 00 SEARCH, 01 LOCKED, 10 HOLD.
- onehot_err  out  1  sticky; set by any accepted non-one-hot flag pattern.
- out_valid  out  1  one-cycle pulse; outputs updated for an accepted sample.

Behaviour:
- Reset values: all counters 0, run_len 0, state SEARCH, lock 0, onehot_err 0, out_valid 0.
- Priority is rst > clr > sample.
- clr sets every output to its reset value. A sample coincident with clr is discarded, and out_valid is 0 the next cycle.
- Latency: 1 cycle. A sample accepted at edge N has all of its effects visible after edge N (registered outputs). out_valid=1 for exactly that cycle.
- Sample classes:
  - valid-less: flags 100.
  - valid-greater: flags 010.
  - valid-eq: flags 001.
  - invalid: any other pattern, including 000.
- Invalid sample: no counter increments; onehot_err set (stays 1 until rst/clr); run_len cleared to 0; treated as a miss by the FSM; out_valid still pulses.
- Counters increment by 1 on their class and hold at 2^CNT_W-1 (no wrap).
- run_len increments on valid-eq and saturates; it clears to 0 on any other accepted sample.
- Cycles with in_valid=0 change nothing; runs and miss counts are preserved across gaps.
- FSM transitions (evaluated only on accepted samples):
  - SEARCH: if the valid-eq sample makes the eq run reach LOCK_LEN -> LOCKED; else stay. The run is measured by the unsaturated internal count, so LOCK_LEN=1 locks on the first eq.
  - LOCKED: valid-eq stays. Miss (non-eq or invalid) -> HOLD with miss_cnt=1; if UNLOCK_LEN==1 -> SEARCH directly.
  - HOLD: valid-eq -> LOCKED, miss_cnt=0. Miss -> miss_cnt+1; when it reaches UNLOCK_LEN -> SEARCH.
  - Encoding 11 is unreachable; if entered, recover to SEARCH on the next edge.
- lock is decoded from the registered state, so it rises one cycle after the LOCK_LEN-th eq sample and stays high through HOLD.
- On entering SEARCH from HOLD, run_len is 0, because the last sample was a miss.

Test Plan:
1. rst held 2 cycles with in_valid=1, eq=1 -> all counts 0, state 00, lock 0, onehot_err 0, out_valid 0.
2. Comparator pairs a/b = 1001/1101, 0101/0001, 1011/1011 fed as less, greater, eq on consecutive cycles -> less_cnt=1, greater_cnt=1, eq_cnt=1, run_len=1, out_valid high 3 cycles each lagging by 1, lock 0.
3. LOCK_LEN=4, UNLOCK_LEN=2:
   - 4 eq samples -> lock=1 and state 01 one cycle after the 4th.
   - then 1 less -> state 10, lock 1, run_len 0.
   - then 1 eq -> state 01.
   - then 2 greater -> state 00, lock 0.
4. CNT_W=4, 20 consecutive less samples -> less_cnt reaches 15 on the 15th and holds 15; other counts 0.
5. In LOCKED, sample less=1, eq=1 -> onehot_err=1, counts unchanged, run_len 0, state 10. A later clr -> onehot_err 0, state 00.
6. clr asserted together with in_valid eq while locked -> next cycle all outputs reset, out_valid 0. Repeat with rst mid-run -> same.

Source files
------------

// File: rtl/comp_result_if.sv
// comp_result_if: comparator flag inputs, soft clear and statistics/lock outputs of the result monitor.
interface comp_result_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             less;
    logic             greater;
    logic             eq;
    logic             clr;
    logic [CNT_W-1:0] less_cnt;
    logic [CNT_W-1:0] greater_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] run_len;
    logic             lock;
    logic [1:0]       state;
    logic             onehot_err;
    logic             out_valid;
    modport master (
        output in_valid, less, greater, eq, clr,
        input  less_cnt, greater_cnt, eq_cnt, run_len, lock, state, onehot_err, out_valid
    );
    modport slave (
        input  in_valid, less, greater, eq, clr,
        output less_cnt, greater_cnt, eq_cnt, run_len, lock, state, onehot_err, out_valid
    );
endinterface

// File: rtl/comp_result_monitor.sv
// comp_result_monitor: per-outcome statistics, eq run tracking, lock FSM with release hysteresis
// and a sticky one-hot error flag for the magnitude comparator's less/greater/eq outputs.
module comp_result_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_LEN   = 4,
    parameter int UNLOCK_LEN = 2
) (
    input logic         clk,
    input logic         rst,
    comp_result_if.slave bus
);
    typedef enum logic [1:0] {SEARCH = 2'b00, LOCKED = 2'b01, HOLD = 2'b10, BAD = 2'b11} state_t;
    state_t       st, st_nx;
    logic [31:0]  miss, miss_nx, miss_inc;
    logic [2:0]   flags;
    logic         is_l, is_g, is_e;
    logic [CNT_W:0] run_inc;
    assign flags    = {bus.less, bus.greater, bus.eq};
    assign is_l     = flags == 3'b100;
    assign is_g     = flags == 3'b010;
    assign is_e     = flags == 3'b001;
    // one extra bit so the lock decision sees the unsaturated run
    assign run_inc  = {1'b0, bus.run_len} + (CNT_W+1)'(1);
    assign miss_inc = miss + 32'd1;
    assign bus.state = st;
    assign bus.lock  = st != SEARCH;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return c + CNT_W'(en && (c != '1));
    endfunction
    always_comb begin
        st_nx   = st;
        miss_nx = miss;
        case (st)
            SEARCH: if (bus.in_valid && is_e && run_inc >= (CNT_W+1)'(LOCK_LEN)) st_nx = LOCKED;
            LOCKED: if (bus.in_valid && !is_e) begin
                st_nx   = UNLOCK_LEN == 1 ? SEARCH : HOLD;
                miss_nx = 32'd1;
            end
            HOLD: if (bus.in_valid) begin
                st_nx   = is_e ? LOCKED : (miss_inc >= 32'(UNLOCK_LEN) ? SEARCH : HOLD);
                miss_nx = is_e ? 32'd0 : miss_inc;
            end
            default: st_nx = SEARCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            st   <= SEARCH;
            miss <= 32'd0;
        end else begin
            st   <= st_nx;
            miss <= miss_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            bus.less_cnt    <= '0;
            bus.greater_cnt <= '0;
            bus.eq_cnt      <= '0;
            bus.run_len     <= '0;
            bus.onehot_err  <= 1'b0;
            bus.out_valid   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.less_cnt    <= sat_inc(bus.less_cnt, is_l);
                bus.greater_cnt <= sat_inc(bus.greater_cnt, is_g);
                bus.eq_cnt      <= sat_inc(bus.eq_cnt, is_e);
                bus.run_len     <= is_e ? sat_inc(bus.run_len, 1'b1) : '0;
                bus.onehot_err  <= bus.onehot_err | !(is_l || is_g || is_e);
            end
        end
    end
endmodule

// File: tb/tb_comp_result_monitor.sv
// tb_comp_result_monitor: directed vectors with hand-computed expectations queued per sample;
// a monitor pops and compares whenever out_valid is seen.
module tb_comp_result_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    typedef struct {int l; int g; int e; int r; int s; int err;} exp_t;
    exp_t q[$];
    comp_result_if #(.CNT_W(4)) bus ();
    comp_result_monitor #(.CNT_W(4), .LOCK_LEN(4), .UNLOCK_LEN(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                exp_t x;
                x = q.pop_front();
                chk("less_cnt", int'(bus.less_cnt), x.l);
                chk("greater_cnt", int'(bus.greater_cnt), x.g);
                chk("eq_cnt", int'(bus.eq_cnt), x.e);
                chk("run_len", int'(bus.run_len), x.r);
                chk("state", int'(bus.state), x.s);
                chk("lock", int'(bus.lock), int'(x.s != 0));
                chk("onehot_err", int'(bus.onehot_err), x.err);
            end
        end
    end
    task automatic drive(input logic v, input logic [2:0] f, input logic c);
        bus.in_valid = v;
        {bus.less, bus.greater, bus.eq} = f;
        bus.clr = c;
    endtask
    task automatic send(input logic [2:0] f, input int l, input int g, input int e,
                        input int r, input int s, input int err);
        drive(1'b1, f, 1'b0);
        q.push_back('{l, g, e, r, s, err});
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 1'b0);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_less_cnt"}, int'(bus.less_cnt), 0);
        chk({tag, "_greater_cnt"}, int'(bus.greater_cnt), 0);
        chk({tag, "_eq_cnt"}, int'(bus.eq_cnt), 0);
        chk({tag, "_run_len"}, int'(bus.run_len), 0);
        chk({tag, "_state"}, int'(bus.state), 0);
        chk({tag, "_lock"}, int'(bus.lock), 0);
        chk({tag, "_onehot_err"}, int'(bus.onehot_err), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    endtask
    task automatic do_clr(input logic with_eq, input string tag);
        drive(with_eq, with_eq ? 3'b001 : 3'b000, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 1'b0);
        check_reset(tag);
    endtask
    initial begin
        drive(1'b1, 3'b001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
        check_reset("reset");
        // less, greater, eq from pairs 1001/1101, 0101/0001, 1011/1011
        send(3'b100, 1, 0, 0, 0, 0, 0);
        send(3'b010, 1, 1, 0, 0, 0, 0);
        send(3'b001, 1, 1, 1, 1, 0, 0);
        idle(1);
        @(negedge clk);
        chk("out_valid_idle", int'(bus.out_valid), 0);
        do_clr(1'b0, "clr1");
        // lock entry with a gap mid-run, hold, relock, release
        send(3'b001, 0, 0, 1, 1, 0, 0);
        send(3'b001, 0, 0, 2, 2, 0, 0);
        idle(2);
        send(3'b001, 0, 0, 3, 3, 0, 0);
        send(3'b001, 0, 0, 4, 4, 1, 0);
        send(3'b100, 1, 0, 4, 0, 2, 0);
        send(3'b001, 1, 0, 5, 1, 1, 0);
        send(3'b010, 1, 1, 5, 0, 2, 0);
        send(3'b010, 1, 2, 5, 0, 0, 0);
        // invalid pattern while locked
        send(3'b001, 1, 2, 6, 1, 0, 0);
        send(3'b001, 1, 2, 7, 2, 0, 0);
        send(3'b001, 1, 2, 8, 3, 0, 0);
        send(3'b001, 1, 2, 9, 4, 1, 0);
        send(3'b101, 1, 2, 9, 0, 2, 1);
        send(3'b001, 1, 2, 10, 1, 1, 1);
        do_clr(1'b0, "clr2");
        // saturation at 15 for CNT_W=4
        for (int i = 1; i <= 20; i++) send(3'b100, (i > 15) ? 15 : i, 0, 0, 0, 0, 0);
        do_clr(1'b0, "clr3");
        send(3'b001, 0, 0, 1, 1, 0, 0);
        send(3'b001, 0, 0, 2, 2, 0, 0);
        send(3'b001, 0, 0, 3, 3, 0, 0);
        send(3'b001, 0, 0, 4, 4, 1, 0);
        do_clr(1'b1, "clr_with_eq");
        send(3'b001, 0, 0, 1, 1, 0, 0);
        send(3'b001, 0, 0, 2, 2, 0, 0);
        rst = 1'b1;
        drive(1'b1, 3'b001, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
        check_reset("rst_mid");
        send(3'b000, 0, 0, 0, 0, 0, 1);
        send(3'b111, 0, 0, 0, 0, 0, 1);
        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
